apu_cmd_rx: RTL

// - Responder for the CPU->APU sound-command write handshake. Snoops DB_I under SCPUB/WRB, commits
//   one byte per completed write strobe into a FIFO, pulses ACK back to the CPU (drives INT1 via APU PB0).
// - Presents buffered bytes to the sound engine through a valid/ready stream; sits beside upd1771c in scv.

---
 rtl/apu_cmd_rx_if.sv | 26 ++
 rtl/apu_cmd_rx.sv | 132 +++++++++++++
 2 files changed

// File: rtl/apu_cmd_rx_if.sv
// rtl/apu_cmd_rx_if.sv - CPU write-strobe bus and command stream bundle for apu_cmd_rx
interface apu_cmd_rx_if #(
  parameter int DEPTH = 8
);
  logic [7:0]             DB_I;
  logic                   SCPUB;
  logic                   WRB;
  logic                   ACK;
  logic [7:0]             CMD_DATA;
  logic                   CMD_VALID;
  logic                   CMD_READY;
  logic [$clog2(DEPTH):0] CMD_LEVEL;
  logic                   OVF;
  logic                   OVF_CLR;
  logic [15:0]            CMD_COUNT;

  modport master (
    output DB_I, SCPUB, WRB, CMD_READY, OVF_CLR,
    input  ACK, CMD_DATA, CMD_VALID, CMD_LEVEL, OVF, CMD_COUNT
  );

  modport slave (
    input  DB_I, SCPUB, WRB, CMD_READY, OVF_CLR,
    output ACK, CMD_DATA, CMD_VALID, CMD_LEVEL, OVF, CMD_COUNT
  );
endinterface

// File: rtl/apu_cmd_rx.sv
// rtl/apu_cmd_rx.sv - CPU->APU sound-command write responder with command FIFO and ACK pulse
// Optional committed-byte counter: define APU_CMD_RX_COUNT_EN.
module apu_cmd_rx #(
  parameter int DEPTH  = 8,
  parameter int FILT   = 2,
  parameter int ACKLEN = 4
) (
  input  logic         CLK,
  input  logic         RESB,
  input  logic         CKEN,
  apu_cmd_rx_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] FILT_W = 3'(FILT);
  localparam logic [3:0] ACK_W  = 4'(ACKLEN);

  typedef enum logic [1:0] {WAIT_HI, IDLE, LOW, COMMIT} state_t;

  state_t     state_q, state_d;
  logic [2:0] filt_q, filt_d;
  logic [7:0] hold_q, hold_d;
  logic       commit;
  logic       sel;

  assign sel = ~bus.SCPUB & ~bus.WRB;

  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      state_q <= WAIT_HI;
      filt_q  <= 3'd0;
      hold_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      filt_q  <= filt_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    filt_d  = filt_q;
    hold_d  = hold_q;
    commit  = 1'b0;
    case (state_q)
      WAIT_HI: if (CKEN && bus.WRB) state_d = IDLE;
      IDLE: begin
        if (CKEN && sel) begin
          state_d = LOW;
          filt_d  = 3'd1;
          hold_d  = bus.DB_I;
        end
      end
      LOW: begin
        if (CKEN) begin
          if (sel) begin
            if (filt_q < FILT_W) filt_d = filt_q + 3'd1;
            hold_d = bus.DB_I;
          end else if (bus.WRB) begin
            state_d = (filt_q >= FILT_W) ? COMMIT : IDLE;
          end else begin
            state_d = WAIT_HI;
          end
        end
      end
      COMMIT: begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = WAIT_HI;
    endcase
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]   wr_q, rd_q, level;
  logic [7:0]    mem [DEPTH];
  logic [7:0]    data_q;
  logic          ovf_q;
  logic [3:0]    ack_cnt;
  logic          empty, full, pop, push_ok, drop;
  logic [AW-1:0] rd_next_idx;

  assign level       = wr_q - rd_q;
  assign empty       = (wr_q == rd_q);
  assign full        = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop         = ~empty & bus.CMD_READY;
  assign push_ok     = commit & (~full | pop);
  assign drop        = commit & full & ~pop;
  assign rd_next_idx = rd_q[AW-1:0] + 1'b1;

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_q[AW-1:0]] <= hold_q;
  end

  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB) begin
      wr_q    <= '0;
      rd_q    <= '0;
      data_q  <= 8'h00;
      ovf_q   <= 1'b0;
      ack_cnt <= 4'd0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
      // Registered head: bypass the pushed byte when the FIFO is (or becomes) empty.
      if (push_ok && (empty || (pop && level == (AW+1)'(1))))
        data_q <= hold_q;
      else if (pop && level >= (AW+1)'(2))
        data_q <= mem[rd_next_idx];
      if (drop)             ovf_q <= 1'b1;
      else if (bus.OVF_CLR) ovf_q <= 1'b0;
      if (commit)                     ack_cnt <= ACK_W;
      else if (CKEN && ack_cnt != 0)  ack_cnt <= ack_cnt - 4'd1;
    end
  end

  assign bus.ACK       = (ack_cnt != 4'd0);
  assign bus.CMD_DATA  = data_q;
  assign bus.CMD_VALID = ~empty;
  assign bus.CMD_LEVEL = level;
  assign bus.OVF       = ovf_q;

`ifdef APU_CMD_RX_COUNT_EN
  logic [15:0] count_q;
  always_ff @(posedge CLK or negedge RESB) begin
    if (!RESB)       count_q <= 16'h0000;
    else if (commit) count_q <= count_q + 16'd1;
  end
  assign bus.CMD_COUNT = count_q;
`else
  assign bus.CMD_COUNT = 16'h0000;
`endif
endmodule
